// File: rtl/spi_pkg.sv
// Shared types and default parameters for the SPI mode-0 master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } spi_state_t;

    localparam int unsigned SPI_DATA_W  = 16;
    localparam int unsigned SPI_CLK_DIV = 4;

endpackage

// File: rtl/flex_counter.sv
// Wrapping up-counter: counts 0..ROLLOVER-1 while enabled, then wraps to 0.
// rollover_flag marks the terminal count and is not qualified by count_enable,
// so the caller gates it with its own enable condition.
module flex_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned ROLLOVER = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic count_enable,
    output logic rollover_flag
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(ROLLOVER - 1);

    logic [WIDTH-1:0] count;

    assign rollover_flag = (count == LAST);

    // Count register: synchronous clear has priority over counting.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) master: one full-duplex MSB-first frame per
// accepted start, framed by SETUP and HOLD guard intervals of CLK_DIV cycles.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = SPI_DATA_W,
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sck,
    output logic              mosi,
    output logic              nss,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam int unsigned HALF_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_W);

    spi_state_t        state;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;

    logic half_tc;
    logic bit_tc;
    logic half_end;
    logic active;

    assign active   = (state != IDLE);
    assign half_end = active && half_tc;

    flex_counter #(
        .WIDTH    (HALF_W),
        .ROLLOVER (CLK_DIV)
    ) u_half_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (!active),
        .count_enable  (active),
        .rollover_flag (half_tc)
    );

    // Advances at the end of each low phase; its terminal count marks the last bit.
    flex_counter #(
        .WIDTH    (BIT_W),
        .ROLLOVER (DATA_W)
    ) u_bit_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (!active),
        .count_enable  ((state == XFER) && half_end && !sck),
        .rollover_flag (bit_tc)
    );

    // Frame sequencer, shift registers and registered SPI/handshake outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            tx_shift <= '0;
            rx_shift <= '0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            nss      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        tx_shift <= tx_data;
                        mosi     <= tx_data[DATA_W-1];
                        nss      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        state <= XFER;
                        sck   <= 1'b1;
                    end
                end
                XFER: begin
                    if (half_end) begin
                        if (sck) begin
                            // End of high phase: sample, then present the next bit
                            // unless this was the last one (mosi keeps the LSB).
                            sck      <= 1'b0;
                            rx_shift <= {rx_shift[DATA_W-2:0], miso};
                            if (!bit_tc) begin
                                tx_shift <= tx_shift << 1;
                                mosi     <= tx_shift[DATA_W-2];
                            end
                        end else if (bit_tc) begin
                            state <= HOLD;
                        end else begin
                            sck <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        state   <= IDLE;
                        rx_data <= rx_shift;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        nss     <= 1'b1;
                        mosi    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: a default build driven by a mode-0 slave
// model, plus a CLK_DIV=1 build with miso looped back to mosi.
module tb_spi_master;

    logic        clk;
    logic        n_rst;

    logic        start;
    logic [15:0] tx_data;
    logic        miso;
    logic        sck, mosi, nss, busy, done;
    logic [15:0] rx_data;

    logic        start1;
    logic [15:0] tx1;
    logic        miso1;
    logic        sck1, mosi1, nss1, busy1, done1;
    logic [15:0] rx1;

    int tests_run;
    int tests_failed;

    // slave model / monitor state
    logic [15:0] slave_word;
    logic [15:0] slave_reg;
    logic [15:0] cap;
    logic        prev_sck, prev_nss;
    int          rises, done_cnt, hi_run, last_gap;

    spi_master dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .start   (start),
        .tx_data (tx_data),
        .miso    (miso),
        .sck     (sck),
        .mosi    (mosi),
        .nss     (nss),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data)
    );

    spi_master #(
        .DATA_W  (16),
        .CLK_DIV (1)
    ) dut1 (
        .clk     (clk),
        .n_rst   (n_rst),
        .start   (start1),
        .tx_data (tx1),
        .miso    (miso1),
        .sck     (sck1),
        .mosi    (mosi1),
        .nss     (nss1),
        .busy    (busy1),
        .done    (done1),
        .rx_data (rx1)
    );

    assign miso1 = mosi1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: wait past the edge, then update the slave model and monitors.
    task automatic step();
        @(posedge clk);
        #1;
        if (sck && !prev_sck) begin
            rises++;
            cap = {cap[14:0], mosi};
        end
        if (!sck && prev_sck) begin
            slave_reg = slave_reg << 1;
            miso      = slave_reg[15];
        end
        if (!nss && prev_nss) begin
            slave_reg = slave_word;
            miso      = slave_reg[15];
            last_gap  = hi_run;
        end
        hi_run   = nss ? hi_run + 1 : 0;
        if (done) done_cnt++;
        prev_sck = sck;
        prev_nss = nss;
    endtask

    // Start one frame; optionally pulse start with FFFF at cycle inject_at.
    task automatic run_frame(input logic [15:0] tx, input logic [15:0] sw,
                             input int inject_at, output int dcyc,
                             output logic [3:0] setup_obs);
        int cyc;
        slave_word = sw;
        tx_data    = tx;
        rises      = 0;
        cap        = '0;
        done_cnt   = 0;
        dcyc       = -1;
        start      = 1'b1;
        step();
        start      = 1'b0;
        setup_obs  = {nss, busy, sck, mosi};
        cyc        = 1;
        while (dcyc < 0 && cyc < 300) begin
            if (cyc == inject_at) begin
                tx_data = 16'hFFFF;
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
            cyc++;
            if (done) dcyc = cyc;
        end
        start = 1'b0;
    endtask

    initial begin
        int         dcyc;
        int         dt[3];
        int         gap12;
        int         t;
        logic [3:0] so;

        tests_run    = 0;
        tests_failed = 0;
        n_rst        = 1'b0;
        start        = 1'b0;
        tx_data      = '0;
        start1       = 1'b0;
        tx1          = '0;
        miso         = 1'b0;
        slave_word   = '0;
        slave_reg    = '0;
        cap          = '0;
        prev_sck     = 1'b0;
        prev_nss     = 1'b1;
        rises        = 0;
        done_cnt     = 0;
        hi_run       = 0;
        last_gap     = 0;
        gap12        = 0;

        // Reset and idle
        repeat (3) step();
        chk("rst_outs", {nss, sck, mosi, busy, done}, 5'b10000);
        chk("rst_rx", rx_data, 16'h0000);
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_outs", {nss, sck, mosi, busy, done}, 5'b10000);
            chk("idle_rx", rx_data, 16'h0000);
        end

        // Basic frame: A5C3 out, 3C5A back
        run_frame(16'hA5C3, 16'h3C5A, -1, dcyc, so);
        chk("a5_setup", so, 4'b0101);
        chk("a5_done_cyc", dcyc, 137);
        chk("a5_rises", rises, 16);
        chk("a5_mosi", cap, 16'hA5C3);
        chk("a5_rx", rx_data, 16'h3C5A);
        chk("a5_end_outs", {nss, sck, busy}, 3'b100);
        step();
        chk("a5_done_pulse", done, 1'b0);
        chk("a5_done_cnt", done_cnt, 1);

        // Start during a frame is ignored, tx_data change has no effect
        repeat (3) step();
        run_frame(16'h00FF, 16'hC0DE, 50, dcyc, so);
        chk("ign_setup", so, 4'b0100);
        chk("ign_done_cyc", dcyc, 137);
        chk("ign_mosi", cap, 16'h00FF);
        chk("ign_rises", rises, 16);
        chk("ign_rx", rx_data, 16'hC0DE);
        repeat (150) step();
        chk("ign_done_cnt", done_cnt, 1);
        chk("ign_idle", {nss, busy}, 2'b10);

        // Back-to-back frames with start held high
        tx_data    = 16'h0001;
        slave_word = 16'h8000;
        cap        = '0;
        done_cnt   = 0;
        start      = 1'b1;
        t          = 0;
        dt         = '{-1, -1, -1};
        while (done_cnt < 3 && t < 600) begin
            step();
            t++;
            if (done) begin
                dt[done_cnt-1] = t;
                if (done_cnt == 2) gap12 = last_gap;
            end
        end
        start = 1'b0;
        chk("b2b_first", dt[0], 137);
        chk("b2b_period1", dt[1] - dt[0], 137);
        chk("b2b_period2", dt[2] - dt[1], 137);
        chk("b2b_gap12", gap12, 1);
        chk("b2b_gap23", last_gap, 1);
        chk("b2b_mosi", cap, 16'h0001);
        chk("b2b_rx", rx_data, 16'h8000);
        repeat (5) step();
        chk("b2b_stop", {nss, busy, done_cnt[3:0]}, 6'b10_0011);

        // Reset asserted mid-frame
        slave_word = 16'hFFFF;
        tx_data    = 16'hFFFF;
        start      = 1'b1;
        step();
        start      = 1'b0;
        for (int c = 1; c < 70; c++) step();
        chk("mid_pre", {nss, sck, busy}, 3'b011);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_outs", {nss, sck, mosi, busy, done}, 5'b10000);
        chk("mid_rst_rx", rx_data, 16'h0000);
        step();
        step();
        chk("mid_rst_hold", {nss, sck, busy}, 3'b100);
        n_rst = 1'b1;
        repeat (2) step();
        run_frame(16'h1234, 16'hABCD, -1, dcyc, so);
        chk("post_done_cyc", dcyc, 137);
        chk("post_mosi", cap, 16'h1234);
        chk("post_rx", rx_data, 16'hABCD);
        chk("post_done_cnt", done_cnt, 1);

        // CLK_DIV=1 build, loopback
        repeat (3) step();
        tx1    = 16'h8001;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        tx1    = 16'h0000;
        begin
            int c1;
            int d1;
            c1 = 1;
            d1 = -1;
            while (d1 < 0 && c1 < 100) begin
                step();
                c1++;
                if (done1) d1 = c1;
            end
            chk("div1_done_cyc", d1, 35);
        end
        chk("div1_rx", rx1, 16'h8001);
        step();
        chk("div1_idle", {nss1, sck1, busy1, done1}, 4'b1000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 master (CPOL=0, CPHA=0) that drives the `spi_fir` slave from on-chip logic. A host strobes `start` with a sample word. The block runs one full-duplex, MSB-first frame on `sck`/`mosi`/`nss`, shifts in the word returned on `miso`, and pulses `done`. It is the initiator counterpart of the FIR's SPI slave and is used in board-level loopback and self-test builds.

## Interface
- `DATA_W`, 16, bits per frame (≥2)
- `CLK_DIV`, 4, `clk` cycles per `sck` half-period (≥1)
- `clk` input 1: system clock, all logic on its rising edge
- `n_rst` input 1: asynchronous, active-low reset
- `start` input 1: frame request, sampled only in IDLE
- `tx_data` input DATA_W: word to send, latched on an accepted `start`
- `miso` input 1: serial data from the slave
- `sck` output 1: SPI clock, idles low
- `mosi` output 1: serial data to the slave, MSB first
- `nss` output 1: active-low slave select
- `busy` output 1: high while a frame is in progress
- `done` output 1: one-cycle pulse when `rx_data` is valid
- `rx_data` output DATA_W: last received word, held until the next `done`

## Operation
- Reset values: `sck`=0, `nss`=1, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0, state IDLE, all counters 0.
- All outputs are registered.
- States and transitions:
  - IDLE → SETUP on `start`=1.
  - SETUP → XFER after CLK_DIV cycles.
  - XFER → HOLD after the high and low phases of DATA_W bits.
  - HOLD → IDLE after CLK_DIV cycles.
- IDLE:
  - `nss`=1, `sck`=0, `mosi`=0, `busy`=0.
  - On `start`, latch `tx_data` into the TX shift register and clear the bit counter.
- SETUP: `nss`=0, `sck`=0, `mosi` = `tx_data[DATA_W-1]`.
- XFER, per bit:
  - High phase: CLK_DIV cycles with `sck`=1.
  - Sampling: at the clk edge that ends the high phase, shift `miso` into the LSB of the RX shift register.
  - Low phase: CLK_DIV cycles with `sck`=0. On entry, `mosi` advances to the next bit. There is no advance after the final bit; `mosi` holds the LSB.
- HOLD: `nss`=0, `sck`=0 for CLK_DIV cycles.
- Return to IDLE, same edge:
  - `rx_data` is loaded from the RX shift register.
  - `done`=1 for exactly one cycle.
  - `busy`=0 and `nss`=1.
- `start` while `busy`=1 is ignored. No queuing, no effect on the frame in progress.
- `start` in the `done` cycle is accepted, because the state is IDLE. `nss` is then high for exactly one cycle between frames.
- `tx_data` changes after acceptance have no effect on the current frame.
- Reset asserted mid-frame: all outputs take their reset values immediately. There is no partial `done`, and `rx_data` returns to 0.

## Timing
- Latency: 1 + 2·CLK_DIV + 2·DATA_W·CLK_DIV cycles from the `start` edge to the `done` cycle. With defaults this is 137.
- Defaults, with cycle 0 as the edge that samples `start`:
  - Cycles 1–4 (SETUP): `nss`=0, `busy`=1.
  - Bit k (k=0 is the MSB) occupies cycles 5+8k … 12+8k: `sck` high for the first 4 cycles, low for the last 4.
  - Cycles 133–136: HOLD.
  - Cycle 137: `done`=1, `busy`=0.
- `sck` period is 2·CLK_DIV `clk` cycles at 50% duty.
- `mosi` is stable for CLK_DIV cycles before each rising `sck`.
- `miso` needs no synchronizer: the slave updates it on falling `sck`, at least CLK_DIV cycles before it is sampled.

## Structure
- Package `spi_pkg` holds:
  - the state enum `spi_state_t` {IDLE, SETUP, XFER, HOLD};
  - the default constants `SPI_DATA_W`=16 and `SPI_CLK_DIV`=4.
- Sub-module `flex_counter` (parameterized width, rollover value, `clear`, `count_enable`, `rollover_flag`) is instantiated twice:
  - half-period counter: rollover CLK_DIV;
  - bit counter: rollover DATA_W, enabled at the end of each low phase.
- FSM, TX shift register, RX shift register and output registers live in `spi_master`.

## Test plan
- Reset, then idle for 20 cycles → `nss`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0 throughout.
- `tx_data`=16'hA5C3, `start` for one cycle, bench slave model returns 16'h3C5A on `miso` → `mosi` bits captured on rising `sck` equal A5C3 MSB first; exactly 16 rising `sck`; `done` in cycle 137; `rx_data`=16'h3C5A.
- Re-assert `start` with 16'hFFFF at cycle 50 of a frame → ignored; the current frame completes unchanged and only one `done` occurs.
- `start` held high continuously with 16'h0001 → back-to-back frames; `nss` high for exactly one cycle between them; `done` every 137 cycles.
- Assert `n_rst`=0 at cycle 70 of a frame → `sck`=0, `nss`=1, `busy`=0, `rx_data`=0 immediately. A later frame with 16'h1234 completes correctly.
- CLK_DIV=1 build, loopback `miso`=`mosi`, `tx_data`=16'h8001 → `done` at cycle 35; `rx_data`=16'h8001.
